channel_allocator: RTL and testbench

CHANNEL_ALLOCATOR -- requirements
Module: channel_allocator

---
 rtl/te_alloc_pkg.sv | 12 +
 rtl/rr_least_bit.sv | 30 +++
 rtl/channel_allocator.sv | 99 +++++++++
 tb/tb_channel_allocator.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/te_alloc_pkg.sv
// Shared definitions for the channel allocator: FSM encoding and default sizing.
package te_alloc_pkg;

    localparam int DEF_NUM_LOGIC = 32;
    localparam int DEF_NUM_PHY   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        FIND = 1'b1
    } state_t;

endpackage

// File: rtl/rr_least_bit.sv
// Combinational search for the first set bit at or above ptr, wrapping around.
module rr_least_bit #(
    parameter int NUM_LOGIC = 32
) (
    input  logic [NUM_LOGIC-1:0]         vec,
    input  logic [$clog2(NUM_LOGIC)-1:0] ptr,
    output logic [$clog2(NUM_LOGIC)-1:0] pos,
    output logic                         active
);

    localparam int IDX_W = $clog2(NUM_LOGIC);

    logic [NUM_LOGIC-1:0] rot;
    logic [IDX_W-1:0]     lz;

    // Rotate so ptr lands at bit 0; the lowest set bit is then the wrap-around winner.
    assign rot = NUM_LOGIC'({vec, vec} >> ptr);

    always_comb begin
        lz = '0;
        for (int i = NUM_LOGIC - 1; i >= 0; i--) begin
            if (rot[i]) lz = IDX_W'(i);
        end
    end

    // NUM_LOGIC is a power of two, so truncation of the sum is the modulo.
    assign pos    = lz + ptr;
    assign active = |vec;

endmodule

// File: rtl/channel_allocator.sv
// Maps enabled logical channels onto a small pool of physical correlator slots,
// one channel per cycle, in lowest-first or round-robin order.
module channel_allocator
    import te_alloc_pkg::*;
#(
    parameter int NUM_LOGIC = DEF_NUM_LOGIC,
    parameter int NUM_PHY   = DEF_NUM_PHY,
    parameter int IDX_W     = $clog2(NUM_LOGIC)
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         latch_enable_channel,
    input  logic [NUM_LOGIC-1:0]         te_channel_enable,
    input  logic                         start_find,
    input  logic                         te_over,
    input  logic                         rr_mode,
    output logic                         busy,
    output logic                         find_channel_done,
    output logic [NUM_LOGIC-1:0]         channel_remain,
    output logic [NUM_PHY-1:0]           physical_channel_en,
    output logic [NUM_PHY*IDX_W-1:0]     logic_channel_index,
    output logic [NUM_PHY*NUM_LOGIC-1:0] logic_channel_mask
);

    localparam int SLOT_W = $clog2(NUM_PHY + 1);

    state_t            state;
    logic [SLOT_W-1:0] slot_cnt;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  search_ptr;
    logic [IDX_W-1:0]  pos;
    logic              active;
    logic              alloc;

    // Lowest-first is just the round-robin search anchored at bit 0.
    assign search_ptr = rr_mode ? rr_ptr : '0;

    rr_least_bit #(
        .NUM_LOGIC (NUM_LOGIC)
    ) u_search (
        .vec    (channel_remain),
        .ptr    (search_ptr),
        .pos    (pos),
        .active (active)
    );

    assign alloc             = (state == FIND) && active && (slot_cnt < SLOT_W'(NUM_PHY));
    assign busy              = (state == FIND);
    assign find_channel_done = (state == FIND) && !alloc;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state               <= IDLE;
            slot_cnt            <= '0;
            rr_ptr              <= '0;
            channel_remain      <= '0;
            physical_channel_en <= '0;
            logic_channel_index <= '0;
            logic_channel_mask  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_find) begin
                        state               <= FIND;
                        slot_cnt            <= '0;
                        physical_channel_en <= '0;
                        logic_channel_index <= '0;
                        logic_channel_mask  <= '0;
                    end
                end
                FIND: begin
                    if (alloc) begin
                        slot_cnt <= slot_cnt + SLOT_W'(1);
                        rr_ptr   <= pos + IDX_W'(1);
                        for (int k = 0; k < NUM_PHY; k++) begin
                            if (slot_cnt == SLOT_W'(k)) begin
                                physical_channel_en[k]                    <= 1'b1;
                                logic_channel_index[k*IDX_W +: IDX_W]     <= pos;
                                logic_channel_mask[k*NUM_LOGIC +: NUM_LOGIC] <= NUM_LOGIC'(1) << pos;
                            end
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // End-of-epoch clear overrides any slot enable set this cycle.
            if (te_over) physical_channel_en <= '0;

            if (latch_enable_channel)
                channel_remain <= te_channel_enable;
            else if (alloc)
                channel_remain[pos] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_channel_allocator.sv
// Directed bench for channel_allocator with the default 32 logical / 4 physical sizing.
module tb_channel_allocator;

    localparam int NL = 32;
    localparam int NP = 4;
    localparam int IW = 5;

    logic              clk = 1'b0;
    logic              rst_b = 1'b0;
    logic              latch_enable_channel = 1'b0;
    logic [NL-1:0]     te_channel_enable = '0;
    logic              start_find = 1'b0;
    logic              te_over = 1'b0;
    logic              rr_mode = 1'b0;
    logic              busy;
    logic              find_channel_done;
    logic [NL-1:0]     channel_remain;
    logic [NP-1:0]     physical_channel_en;
    logic [NP*IW-1:0]  logic_channel_index;
    logic [NP*NL-1:0]  logic_channel_mask;

    int checks = 0;
    int errors = 0;

    channel_allocator dut (
        .clk                  (clk),
        .rst_b                (rst_b),
        .latch_enable_channel (latch_enable_channel),
        .te_channel_enable    (te_channel_enable),
        .start_find           (start_find),
        .te_over              (te_over),
        .rr_mode              (rr_mode),
        .busy                 (busy),
        .find_channel_done    (find_channel_done),
        .channel_remain       (channel_remain),
        .physical_channel_en  (physical_channel_en),
        .logic_channel_index  (logic_channel_index),
        .logic_channel_mask   (logic_channel_mask)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] idx(input int k);
        return 64'(logic_channel_index[k*IW +: IW]);
    endfunction

    function automatic logic [63:0] msk(input int k);
        return 64'(logic_channel_mask[k*NL +: NL]);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic latch(input logic [NL-1:0] v);
        latch_enable_channel = 1'b1;
        te_channel_enable    = v;
        step();
        latch_enable_channel = 1'b0;
    endtask

    // Pulses start_find; returns in FIND cycle 1.
    task automatic start();
        start_find = 1'b1;
        step();
        start_find = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(find_channel_done), 64'd0);
        chk("rst_remain", 64'(channel_remain), 64'd0);
        chk("rst_en", 64'(physical_channel_en), 64'd0);
        chk("rst_index", 64'(logic_channel_index), 64'd0);
        chk("rst_mask0", msk(0), 64'd0);
        step();
        rst_b = 1'b1;
        step();

        // Empty pass: done immediately, busy for one cycle
        start();
        chk("empty_busy", 64'(busy), 64'd1);
        chk("empty_done", 64'(find_channel_done), 64'd1);
        step();
        chk("empty_busy_after", 64'(busy), 64'd0);
        chk("empty_done_after", 64'(find_channel_done), 64'd0);
        chk("empty_en", 64'(physical_channel_en), 64'd0);

        // te_over during second allocation; leaves rr_ptr at 2
        latch(32'h0000_0003);
        chk("teo_remain", 64'(channel_remain), 64'h3);
        start();
        chk("teo_done_c1", 64'(find_channel_done), 64'd0);
        step();
        chk("teo_en_c2", 64'(physical_channel_en), 64'h1);
        te_over = 1'b1;
        step();
        te_over = 1'b0;
        chk("teo_en", 64'(physical_channel_en), 64'h0);
        chk("teo_mask1", msk(1), 64'h2);
        chk("teo_index1", idx(1), 64'd1);
        chk("teo_mask0", msk(0), 64'h1);
        chk("teo_remain_after", 64'(channel_remain), 64'h0);
        chk("teo_done", 64'(find_channel_done), 64'd1);
        step();
        chk("teo_busy_after", 64'(busy), 64'd0);

        // Round-robin from rr_ptr 2 wraps past the top
        rr_mode = 1'b1;
        latch(32'h8000_0003);
        start();
        step();
        step();
        step();
        chk("rr_done", 64'(find_channel_done), 64'd1);
        chk("rr_idx0", idx(0), 64'd31);
        chk("rr_idx1", idx(1), 64'd0);
        chk("rr_idx2", idx(2), 64'd1);
        chk("rr_mask0", msk(0), 64'h8000_0000);
        chk("rr_en", 64'(physical_channel_en), 64'h7);
        step();
        // rr_ptr is 2 again: of bits {0,2}, bit 2 comes first
        latch(32'h0000_0005);
        start();
        step();
        chk("rr_ptr_idx0", idx(0), 64'd2);
        chk("rr_ptr_idx1_next", 64'(find_channel_done), 64'd0);
        step();
        chk("rr_ptr_idx1", idx(1), 64'd0);
        chk("rr_ptr_done", 64'(find_channel_done), 64'd1);
        step();

        // Lowest-first: 0xF0 -> 4,5,6,7, done in 5th FIND cycle
        rr_mode = 1'b0;
        latch(32'h0000_00F0);
        start();
        for (int c = 1; c <= 4; c++) begin
            chk("lf_done_early", 64'(find_channel_done), 64'd0);
            step();
        end
        chk("lf_done", 64'(find_channel_done), 64'd1);
        chk("lf_idx0", idx(0), 64'd4);
        chk("lf_idx1", idx(1), 64'd5);
        chk("lf_idx2", idx(2), 64'd6);
        chk("lf_idx3", idx(3), 64'd7);
        chk("lf_mask3", msk(3), 64'h80);
        chk("lf_en", 64'(physical_channel_en), 64'hF);
        chk("lf_remain", 64'(channel_remain), 64'h0);
        step();

        // Two passes over 0x3F
        latch(32'h0000_003F);
        start();
        step(); step(); step(); step();
        chk("p1_done", 64'(find_channel_done), 64'd1);
        chk("p1_idx0", idx(0), 64'd0);
        chk("p1_idx3", idx(3), 64'd3);
        chk("p1_remain", 64'(channel_remain), 64'h30);
        step();
        start();
        chk("p2_cleared_en", 64'(physical_channel_en), 64'h0);
        chk("p2_cleared_idx3", idx(3), 64'd0);
        start_find = 1'b1;   // ignored while busy
        step();
        start_find = 1'b0;
        step();
        chk("p2_done", 64'(find_channel_done), 64'd1);
        chk("p2_idx0", idx(0), 64'd4);
        chk("p2_idx1", idx(1), 64'd5);
        chk("p2_en", 64'(physical_channel_en), 64'h3);
        chk("p2_remain", 64'(channel_remain), 64'h0);
        step();
        chk("p2_idle", 64'(busy), 64'd0);

        // Reset mid-pass
        latch(32'h0000_000F);
        start();
        step();
        chk("mid_en_before", 64'(physical_channel_en), 64'h1);
        #2;
        rst_b = 1'b0;
        #1;
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_done", 64'(find_channel_done), 64'd0);
        chk("mid_en", 64'(physical_channel_en), 64'h0);
        chk("mid_remain", 64'(channel_remain), 64'h0);
        chk("mid_index", 64'(logic_channel_index), 64'd0);
        chk("mid_mask0", msk(0), 64'd0);
        step();
        chk("mid_done_held", 64'(find_channel_done), 64'd0);
        rst_b = 1'b1;
        step();
        chk("mid_done_post", 64'(find_channel_done), 64'd0);
        chk("mid_busy_post", 64'(busy), 64'd0);

        // Clean pass after reset; round-robin from a reset rr_ptr of 0
        rr_mode = 1'b1;
        latch(32'h0000_0003);
        start();
        step();
        step();
        chk("post_done", 64'(find_channel_done), 64'd1);
        chk("post_idx0", idx(0), 64'd0);
        chk("post_idx1", idx(1), 64'd1);
        chk("post_en", 64'(physical_channel_en), 64'h3);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
